// File: rtl/shortcut_time_setter.sv
// Shortcut time setter: adds keypad preset durations (optionally accumulated) to the
// current BCD time using a five-step digit-serial adder, then strobes `complete`.
module shortcut_time_setter #(
    parameter int                      NUM_KEYS    = 10,
    parameter int                      NUM_PRESETS = 4,
    parameter logic [24*NUM_PRESETS-1:0] PRESETS   = {24'h000500, 24'h000100, 24'h000030, 24'h000005},
    parameter bit                      ACCUMULATE  = 1'b1,
    parameter bit                      WRAP_24H    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                sharp,
    input  logic [23:0]         time_in,
    output logic [23:0]         time_out,
    output logic [23:0]         offset_out,
    output logic                busy,
    output logic                complete,
    output logic                overflow
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_ACC     = 3'd2;
    localparam logic [2:0] S_ADD     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]          state_reg, state_next;
    logic [NUM_KEYS-1:0] key_prev_reg;
    logic                sharp_prev_reg;
    logic [2:0]          step_reg;
    logic                carry_reg;
    logic [23:0]         op_a_reg, op_b_reg;
    logic [15:0]         sum_reg;
    logic [23:0]         offset_reg, time_out_reg;
    logic                overflow_reg, complete_reg, busy_reg;

    logic [NUM_KEYS-1:0] key_press;
    logic                sharp_press;
    logic [23:0]         preset_arr [NUM_PRESETS];
    logic                key_hit;
    logic [23:0]         key_preset;

    generate
        for (genvar gi = 0; gi < NUM_PRESETS; gi++) begin : g_preset
            assign preset_arr[gi] = PRESETS[24*gi +: 24];
        end
    endgenerate

    assign key_press   = keypad & ~key_prev_reg;
    assign sharp_press = sharp & ~sharp_prev_reg;

    // Scan downwards so the lowest-index simultaneous press is the one kept.
    always_comb begin
        key_hit    = 1'b0;
        key_preset = '0;
        for (int i = NUM_PRESETS - 1; i >= 0; i--) begin
            if (key_press[i]) begin
                key_hit    = 1'b1;
                key_preset = preset_arr[i];
            end
        end
    end

    // One minute/second digit per step: s1, s10, m1, m10.
    logic [3:0] dig_a, dig_b, dig_mod, dig_res;
    logic [4:0] dig_sum, dig_sub;
    logic       dig_carry;

    always_comb begin
        dig_a   = op_a_reg[3:0];
        dig_b   = op_b_reg[3:0];
        dig_mod = 4'd10;
        case (step_reg)
            3'd1: begin dig_a = op_a_reg[7:4];   dig_b = op_b_reg[7:4];   dig_mod = 4'd6;  end
            3'd2: begin dig_a = op_a_reg[11:8];  dig_b = op_b_reg[11:8];  dig_mod = 4'd10; end
            3'd3: begin dig_a = op_a_reg[15:12]; dig_b = op_b_reg[15:12]; dig_mod = 4'd6;  end
            default: ;
        endcase
    end

    assign dig_sum   = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_reg};
    assign dig_sub   = dig_sum - {1'b0, dig_mod};
    assign dig_carry = (dig_sum >= {1'b0, dig_mod});
    assign dig_res   = dig_carry ? dig_sub[3:0] : dig_sum[3:0];

    // Hours are handled as a single binary field so the mod-24 wrap is one compare.
    logic [7:0]  hr_a, hr_b, hr_sum, hr_wrap, hr_tens, hr_ones;
    logic        hr_ovf, sat_result;
    logic [23:0] add_res;

    assign hr_a    = {4'd0, op_a_reg[23:20]} * 8'd10 + {4'd0, op_a_reg[19:16]};
    assign hr_b    = {4'd0, op_b_reg[23:20]} * 8'd10 + {4'd0, op_b_reg[19:16]};
    assign hr_sum  = hr_a + hr_b + {7'd0, carry_reg};
    assign hr_ovf  = (hr_sum >= 8'd24);
    assign hr_wrap = hr_sum % 8'd24;
    assign hr_tens = hr_wrap / 8'd10;
    assign hr_ones = hr_wrap % 8'd10;

    // The accumulated offset always saturates; only the final target may wrap.
    assign sat_result = (state_reg == S_ACC) || !WRAP_24H;
    assign add_res    = (hr_ovf && sat_result) ? 24'h235959
                                               : {hr_tens[3:0], hr_ones[3:0], sum_reg};

    logic unused_bits;
    assign unused_bits = ^{key_press, hr_tens[7:4], hr_ones[7:4], dig_sum[4], dig_sub[4]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (en) state_next = S_COLLECT;
            S_COLLECT: begin
                if (key_hit) begin
                    if (ACCUMULATE) state_next = S_ACC;
                end else if (sharp_press && offset_reg != '0) begin
                    state_next = S_ADD;
                end
            end
            S_ACC:     if (step_reg == 3'd4) state_next = S_COLLECT;
            S_ADD:     if (step_reg == 3'd4) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (!en && state_reg != S_DONE) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            key_prev_reg   <= '0;
            sharp_prev_reg <= 1'b0;
            step_reg       <= '0;
            carry_reg      <= 1'b0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            sum_reg        <= '0;
            offset_reg     <= '0;
            time_out_reg   <= '0;
            overflow_reg   <= 1'b0;
            complete_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            key_prev_reg   <= keypad;
            sharp_prev_reg <= sharp;
            state_reg      <= state_next;
            busy_reg       <= (state_next == S_ACC) || (state_next == S_ADD);
            complete_reg   <= 1'b0;
            case (state_reg)
                S_COLLECT: begin
                    if (!en) begin
                        offset_reg <= '0;
                    end else if (key_hit) begin
                        if (ACCUMULATE) begin
                            op_a_reg  <= offset_reg;
                            op_b_reg  <= key_preset;
                            step_reg  <= '0;
                            carry_reg <= 1'b0;
                        end else begin
                            offset_reg <= key_preset;
                        end
                    end else if (sharp_press && offset_reg != '0) begin
                        op_a_reg  <= time_in;
                        op_b_reg  <= offset_reg;
                        step_reg  <= '0;
                        carry_reg <= 1'b0;
                    end
                end
                S_ACC, S_ADD: begin
                    if (!en) begin
                        offset_reg <= '0;
                    end else if (step_reg == 3'd4) begin
                        if (state_reg == S_ACC) begin
                            offset_reg <= add_res;
                        end else begin
                            time_out_reg <= add_res;
                            overflow_reg <= hr_ovf;
                            complete_reg <= 1'b1;
                        end
                    end else begin
                        step_reg  <= step_reg + 3'd1;
                        carry_reg <= dig_carry;
                        case (step_reg)
                            3'd0:    sum_reg[3:0]   <= dig_res;
                            3'd1:    sum_reg[7:4]   <= dig_res;
                            3'd2:    sum_reg[11:8]  <= dig_res;
                            default: sum_reg[15:12] <= dig_res;
                        endcase
                    end
                end
                default: offset_reg <= '0;
            endcase
        end
    end

    assign time_out   = time_out_reg;
    assign offset_out = offset_reg;
    assign busy       = busy_reg;
    assign complete   = complete_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_shortcut_time_setter.sv
// Bench for shortcut_time_setter: an accumulating/wrapping instance and a
// replacing/saturating instance share stimulus and are checked against a seconds-based model.
module tb_shortcut_time_setter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        sharp = 1'b0;
    logic [9:0]  keypad = '0;
    logic [23:0] time_in = '0;

    logic [23:0] tout [2];
    logic [23:0] oout [2];
    logic        busy_w [2];
    logic        comp_w [2];
    logic        ovf_w [2];

    int checks = 0;
    int errors = 0;

    // Model state: offsets in seconds, expected held outputs.
    int          off_s [2];
    logic [23:0] exp_tout [2];
    logic        exp_ovf [2];
    int          preset_s [4] = '{5, 30, 60, 300};

    always #5 clk = ~clk;

    shortcut_time_setter #(.NUM_KEYS(10), .NUM_PRESETS(4), .ACCUMULATE(1'b1), .WRAP_24H(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .keypad(keypad), .sharp(sharp), .time_in(time_in),
        .time_out(tout[0]), .offset_out(oout[0]), .busy(busy_w[0]), .complete(comp_w[0]),
        .overflow(ovf_w[0])
    );

    shortcut_time_setter #(.NUM_KEYS(10), .NUM_PRESETS(4), .ACCUMULATE(1'b0), .WRAP_24H(1'b0)) dut_rep (
        .clk(clk), .rst(rst), .en(en), .keypad(keypad), .sharp(sharp), .time_in(time_in),
        .time_out(tout[1]), .offset_out(oout[1]), .busy(busy_w[1]), .complete(comp_w[1]),
        .overflow(ovf_w[1])
    );

    function automatic logic [23:0] sec2bcd(input int s);
        int h = s / 3600;
        int m = (s / 60) % 60;
        int c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int lowest_preset(input logic [9:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_off%0d", tag, i), oout[i], sec2bcd(off_s[i]));
            check_val($sformatf("%s_tout%0d", tag, i), tout[i], exp_tout[i]);
            check_val($sformatf("%s_ovf%0d", tag, i), ovf_w[i], exp_ovf[i]);
            check_val($sformatf("%s_cmp%0d", tag, i), comp_w[i], 0);
        end
    endtask

    // One key-press transaction; `mid` is pressed while the accumulating instance is busy.
    task automatic press(input logic [9:0] mask, input logic [9:0] mid);
        int w    = lowest_preset(mask);
        int wm   = lowest_preset(mid);
        int old0 = off_s[0];
        keypad = mask;
        tick();
        keypad = '0;
        if (w >= 0) off_s[1] = preset_s[w];
        check_val("rep_off_next", oout[1], sec2bcd(off_s[1]));
        check_val("acc_busy", busy_w[0], (w >= 0) ? 1 : 0);
        check_val("rep_busy", busy_w[1], 0);
        tick();
        keypad = (w >= 0) ? mid : 10'd0;
        tick();
        keypad = '0;
        if (w >= 0 && wm >= 0) off_s[1] = preset_s[wm];
        tick();
        tick();
        check_val("acc_off_hold", oout[0], sec2bcd(old0));
        tick();
        if (w >= 0) off_s[0] = (old0 + preset_s[w] > 86399) ? 86399 : old0 + preset_s[w];
        check_val("acc_busy_end", busy_w[0], 0);
        check_held("press");
        $display("press mask=%03h mid=%03h offsets %06h %06h", mask, mid, oout[0], oout[1]);
    endtask

    task automatic commit(input int ts);
        int tot;
        time_in = sec2bcd(ts);
        sharp = 1'b1;
        tick();
        sharp = 1'b0;
        time_in = sec2bcd(int'($urandom_range(0, 86399)));
        if (off_s[0] != 0) begin
            for (int i = 0; i < 2; i++) begin
                tot = ts + off_s[i];
                exp_ovf[i] = (tot >= 86400);
                if (tot >= 86400) tot = (i == 0) ? tot - 86400 : 86399;
                exp_tout[i] = sec2bcd(tot);
            end
            for (int c = 0; c < 5; c++) begin
                for (int i = 0; i < 2; i++) begin
                    check_val($sformatf("add_busy%0d_c%0d", i, c), busy_w[i], 1);
                    check_val($sformatf("add_cmp%0d_c%0d", i, c), comp_w[i], 0);
                end
                if (c < 4) tick();
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                check_val($sformatf("done_cmp%0d", i), comp_w[i], 1);
                check_val($sformatf("done_tout%0d", i), tout[i], exp_tout[i]);
                check_val($sformatf("done_ovf%0d", i), ovf_w[i], exp_ovf[i]);
                check_val($sformatf("done_busy%0d", i), busy_w[i], 0);
            end
            off_s[0] = 0;
            off_s[1] = 0;
            tick();
            check_held("after_done");
            tick();
        end else begin
            for (int c = 0; c < 7; c++) begin
                for (int i = 0; i < 2; i++) begin
                    check_val($sformatf("nocmp%0d", i), comp_w[i], 0);
                    check_val($sformatf("nobusy%0d", i), busy_w[i], 0);
                end
                tick();
            end
        end
        $display("commit time=%06h results %06h/%0d %06h/%0d", sec2bcd(ts), tout[0], ovf_w[0],
                 tout[1], ovf_w[1]);
    endtask

    task automatic abort_en();
        en = 1'b0;
        tick();
        off_s[0] = 0;
        off_s[1] = 0;
        check_held("abort");
        en = 1'b1;
        tick();
        check_held("abort_back");
        $display("abort offsets %06h %06h", oout[0], oout[1]);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            off_s[i] = 0;
            exp_tout[i] = '0;
            exp_ovf[i] = 1'b0;
        end
        #1;
        check_held("reset");
        check_val("reset_busy", busy_w[0], 0);
        tick();
        tick();
        rst = 1'b1;
        en = 1'b1;
        tick();

        // Basic add, accumulation, day boundary.
        press(10'b0000000010, '0);
        commit(12*3600 + 34*60 + 45);
        press(10'b0000000100, '0);
        press(10'b0000000100, '0);
        press(10'b0000000001, '0);
        commit(58*60);
        press(10'b0000000001, '0);
        commit(23*3600 + 59*60 + 58);

        // Input hygiene.
        keypad = 10'b0000000010;
        tick();
        off_s[0] = (off_s[0] + 30 > 86399) ? 86399 : off_s[0] + 30;
        off_s[1] = 30;
        for (int c = 0; c < 19; c++) tick();
        keypad = '0;
        tick();
        check_held("hold");
        $display("hold key1 offsets %06h %06h", oout[0], oout[1]);
        press(10'b0000001010, '0);
        commit(3600);
        press(10'b1000000000, '0);
        commit(7200);
        press(10'b0000000010, 10'b0000001000);
        commit(10*3600 + 5);
        press(10'b0000000100, '0);
        abort_en();

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 6) begin
                if (r < 3) press(10'(1 << $urandom_range(0, 9)), '0);
                else       press(10'($urandom_range(0, 1023)), '0);
            end else if (r < 9) begin
                commit(int'($urandom_range(0, 86399)));
            end else begin
                abort_en();
            end
        end

        // Reset during the third ADD cycle.
        press(10'b0000000010, '0);
        time_in = 24'h120000;
        sharp = 1'b1;
        tick();
        sharp = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            off_s[i] = 0;
            exp_tout[i] = '0;
            exp_ovf[i] = 1'b0;
            check_val($sformatf("rst_busy%0d", i), busy_w[i], 0);
        end
        check_held("rst_mid");
        $display("reset during add offsets %06h %06h", oout[0], oout[1]);
        tick();
        tick();
        rst = 1'b1;
        tick();
        press(10'b0000000001, '0);
        commit(int'($urandom_range(0, 86399)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shortcut_time_setter.md
# shortcut_time_setter

Parametrised successor to the fixed three-shortcut setter. It adds up to NUM_PRESETS keypad shortcut durations, optionally accumulating several presses, to the current clock time. The target time is computed with a digit-serial BCD adder and returned with a one-cycle `complete` strobe. It sits between the keypad/`#` decoder and the alarm/nap target register in the clock datapath.

## Interface
- `NUM_KEYS`, default 10: keypad width. Key k is active on `keypad[k]`.
- `NUM_PRESETS`, default 4: keys 0..NUM_PRESETS-1 are shortcuts. Requires 1 ≤ NUM_PRESETS ≤ NUM_KEYS.
- `PRESETS`, default {24'h000500, 24'h000100, 24'h000030, 24'h000005}: packed BCD hh:mm:ss, 24 bits per preset; preset i occupies bits [24i+23:24i].
- `ACCUMULATE`, default 1: when 1, presses add to the offset; when 0, the last press replaces it.
- `WRAP_24H`, default 1: when 1, hours wrap modulo 24; when 0, the result saturates at 23:59:59.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  setter mode enable, level.
- `keypad`  in  NUM_KEYS  raw key levels, already synchronised.
- `sharp`  in  1  `#` key level; acts as commit.
- `time_in`  in  24  current time, BCD {h10,h1,m10,m1,s10,s1}.
- `time_out`  out  24  target time, same format.
- `offset_out`  out  24  accumulated offset, for display.
- `busy`  out  1  high in states ACC and ADD.
- `complete`  out  1  one-cycle strobe; `time_out` is valid in the same cycle.
- `overflow`  out  1  valid with `complete`: result passed 23:59:59 (wrapped or saturated).

## Operation
- Edge detection: `keypad` and `sharp` are registered each cycle. A press means bit=1 now and 0 on the previous cycle. A held key counts once.
- States: IDLE, COLLECT, ACC, ADD, DONE.
- IDLE: offset cleared. `en`=1 → COLLECT.
- COLLECT, preset key press:
  - Several new presses in the same cycle: the lowest index wins.
  - Non-preset keys are ignored.
  - ACCUMULATE=1: → ACC with operands (offset, PRESETS[i]).
  - ACCUMULATE=0: offset ← PRESETS[i] directly; stay in COLLECT.
- COLLECT, `sharp` press:
  - offset ≠ 0: snapshot `time_in`, → ADD with operands (snapshot, offset).
  - offset = 0: ignored.
  - `sharp` and a key press in the same cycle: the key wins; `sharp` is dropped.
- ACC and ADD share one digit-serial adder, 5 steps:
  - steps: s1 (mod 10), s10 (mod 6), m1 (mod 10), m10 (mod 6), hours (two-digit field, mod 24).
  - carry propagates between steps.
  - ACC result saturates at 23:59:59 regardless of WRAP_24H. Then → COLLECT.
  - ADD result: WRAP_24H=1 → hours mod 24; WRAP_24H=0 → clamp to 23:59:59. Either case sets `overflow`. Then → DONE.
- Key or `sharp` presses during ACC/ADD are ignored, not queued.
- DONE, one cycle: `complete`=1, `time_out` and `overflow` updated; offset cleared; → IDLE.
- `en`=0 in any state except DONE → IDLE next cycle. Offset cleared, no `complete`, `time_out` unchanged.
- `time_in` must be valid BCD ≤ 23:59:59; otherwise the result is undefined.

## Timing
- Reset values: `time_out`=0, `offset_out`=0, `busy`=0, `complete`=0, `overflow`=0, state IDLE, edge registers 0.
- Reset asserted mid-ACC or mid-ADD aborts immediately; no `complete`.
- `sharp` press sampled at edge t → ADD occupies cycles t+1..t+5 → `complete` high in cycle t+6. Total latency 6 cycles.
- A key press sampled at edge t (ACCUMULATE=1) → `offset_out` updates after edge t+5. The next press is accepted from cycle t+6.
- ACCUMULATE=0: `offset_out` updates one cycle after the press.
- `busy` is registered and tracks the state exactly.
- `overflow` holds its value until the next `complete`.

## Test plan
- Basic add: en=1; press key1; `time_in`=12:34:45; press `sharp` → `complete` 6 cycles later, `time_out`=12:35:15, `overflow`=0.
- Accumulation: presses key2, key2, key0 → `offset_out`=00:02:05. `time_in`=00:58:00, `sharp` → `time_out`=01:00:05. Repeat with ACCUMULATE=0 → `offset_out`=00:00:05, `time_out`=00:58:05.
- Day boundary: `time_in`=23:59:58 + key0 → WRAP_24H=1: `time_out`=00:00:03, `overflow`=1. WRAP_24H=0: `time_out`=23:59:59, `overflow`=1.
- Input hygiene:
  - key1 held 20 cycles → offset 00:00:30 (counted once).
  - keys 1 and 3 pressed together → 00:00:30 (key1 wins).
  - key3 pressed during ACC → ignored.
  - key 9 pressed → ignored.
  - `sharp` with offset 0 → no `complete`.
- Abort: en drops in COLLECT with offset 00:01:00 → IDLE, `offset_out`=0, no `complete`, `time_out` unchanged.
- Reset: rst=0 during the 3rd ADD cycle → all outputs 0 immediately. After release, a new en/key/`sharp` sequence completes normally.
